// File: rtl/gf2m_operand_loader.sv
// gf2m_operand_loader: assembles a/g/b operands from a word stream, pulses start and
// holds the operands until the multiplier reports done.
module gf2m_operand_loader #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 8,
  parameter int WORD_W     = 32,
  localparam int BWIDTH    = (DATA_WIDTH / DIGITAL + 1) * DIGITAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] op_a_o,
  output logic [DATA_WIDTH-1:0] op_g_o,
  output logic [BWIDTH-1:0]     op_b_o,
  output logic                  start_o,
  input  logic                  mul_done_i,
  output logic                  busy_o,
  output logic [15:0]           ops_issued_o
);
  localparam int MAXW  = (DATA_WIDTH > BWIDTH) ? DATA_WIDTH : BWIDTH;
  localparam int WPO   = (MAXW + WORD_W - 1) / WORD_W;
  localparam int TOTAL = 3 * WPO;
  localparam int IW    = $clog2(TOTAL);

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  in_ready_q, done_q;
  logic [15:0]           ops_q, ops_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_g_q, op_g_d;
  logic [BWIDTH-1:0]     op_b_q, op_b_d;
  logic [IW-1:0]         seg, k;
  logic [31:0]           sh;
  logic                  last;

  assign seg  = idx_q / IW'(WPO);
  assign k    = idx_q % IW'(WPO);
  assign sh   = 32'(k) * 32'(WORD_W);
  assign last = idx_q == IW'(TOTAL - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    op_a_d  = op_a_q;
    op_g_d  = op_g_q;
    op_b_d  = op_b_q;
    if (state_q == S_LOAD) begin
      if (flush_i) idx_d = '0;
      else if (in_valid_i && in_ready_q) begin
        idx_d   = last ? '0 : idx_q + IW'(1);
        state_d = last ? S_FIRE : S_LOAD;
        // Shifting into the operand width drops bits above the top of the operand.
        if (seg == IW'(0)) op_a_d = (op_a_q & ~(DATA_WIDTH'({WORD_W{1'b1}}) << sh)) | (DATA_WIDTH'(in_data_i) << sh);
        if (seg == IW'(1)) op_g_d = (op_g_q & ~(DATA_WIDTH'({WORD_W{1'b1}}) << sh)) | (DATA_WIDTH'(in_data_i) << sh);
        if (seg == IW'(2)) op_b_d = (op_b_q & ~(BWIDTH'({WORD_W{1'b1}}) << sh)) | (BWIDTH'(in_data_i) << sh);
      end
    end else if (state_q == S_FIRE) begin
      state_d = S_WAIT;
      ops_d   = ops_q + 16'd1;
    end else if (mul_done_i && !done_q) state_d = S_LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      ops_q      <= '0;
      op_a_q     <= '0;
      op_g_q     <= '0;
      op_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= state_d == S_LOAD;
      done_q     <= mul_done_i;
      ops_q      <= ops_d;
      op_a_q     <= op_a_d;
      op_g_q     <= op_g_d;
      op_b_q     <= op_b_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign op_a_o       = op_a_q;
  assign op_g_o       = op_g_q;
  assign op_b_o       = op_b_q;
  assign start_o      = state_q == S_FIRE;
  assign busy_o       = state_q != S_LOAD;
  assign ops_issued_o = ops_q;
endmodule

// File: tb/tb_gf2m_operand_loader.sv
// tb_gf2m_operand_loader: directed bench for the operand loader with hand-computed expectations.
module tb_gf2m_operand_loader;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [162:0] op_a, op_g;
  logic [167:0] op_b;
  logic         start;
  logic         mul_done = 1'b0;
  logic         busy;
  logic [15:0]  ops_issued;
  int checks = 0;
  int errors = 0;
  logic [191:0] pat;
  int           seen;

  gf2m_operand_loader dut (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .op_a_o(op_a), .op_g_o(op_g), .op_b_o(op_b), .start_o(start),
    .mul_done_i(mul_done), .busy_o(busy), .ops_issued_o(ops_issued)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("ready_timeout", 256'(in_ready), 256'(1));
    step();
  endtask

  task automatic load(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ready"}, 256'(in_ready), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_start"}, 256'(start), 256'(0));
    check({tag, "_ops"}, 256'(ops_issued), 256'(0));
    check({tag, "_a"}, 256'(op_a), 256'(0));
    check({tag, "_g"}, 256'(op_g), 256'(0));
    check({tag, "_b"}, 256'(op_b), 256'(0));
  endtask

  initial begin
    #1 rst = 1'b0;
    step();
    step();
    reset_check("rst");
    rst = 1'b1;
    check("ready_before_edge", 256'(in_ready), 256'(0));
    step();
    check("ready_after_release", 256'(in_ready), 256'(1));

    // Zero-bubble load of all ones.
    load(32'hFFFF_FFFF, 18);
    check("ones_start", 256'(start), 256'(1));
    check("ones_busy", 256'(busy), 256'(1));
    check("ones_ready_fire", 256'(in_ready), 256'(0));
    check("ones_a", 256'(op_a), 256'({163{1'b1}}));
    check("ones_g", 256'(op_g), 256'({163{1'b1}}));
    check("ones_b", 256'(op_b), 256'({168{1'b1}}));
    in_data = 32'hDEAD_BEEF;
    step();
    check("ones_start_once", 256'(start), 256'(0));
    check("ones_ops", 256'(ops_issued), 256'(1));

    // WAIT ignores in_valid until a fresh mul_done rise.
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready || !busy) seen++;
      step();
    end
    check("wait_no_accept", 256'(seen), 256'(0));
    check("wait_a_held", 256'(op_a), 256'({163{1'b1}}));
    mul_done = 1'b1;
    step();
    in_valid = 1'b0;
    check("rearm_ready", 256'(in_ready), 256'(1));
    check("rearm_busy", 256'(busy), 256'(0));
    mul_done = 1'b0;

    // Counting words with gaps between them.
    for (int i = 1; i < 18; i++) begin
      send(32'(i));
      in_valid = 1'b0;
      step();
    end
    send(32'd18);
    in_valid = 1'b0;
    check("gap_start", 256'(start), 256'(1));
    check("gap_a", 256'(op_a), 256'({3'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
    check("gap_g", 256'(op_g), 256'({3'd4, 32'd11, 32'd10, 32'd9, 32'd8, 32'd7}));
    check("gap_b", 256'(op_b), 256'({8'h12, 32'd17, 32'd16, 32'd15, 32'd14, 32'd13}));
    step();
    check("gap_ops", 256'(ops_issued), 256'(2));
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    check("gap_rearm", 256'(in_ready), 256'(1));

    // Partial load, flush coinciding with a valid word, then a full load.
    load(32'h1111_1111, 10);
    in_data = 32'h1234_5678;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    check("flush_no_start", 256'(start), 256'(0));
    check("flush_ready", 256'(in_ready), 256'(1));
    load(32'hA5A5_A5A5, 17);
    check("flush_not_early", 256'(start), 256'(0));
    send(32'hA5A5_A5A5);
    in_valid = 1'b0;
    pat = {6{32'hA5A5_A5A5}};
    check("flush_start", 256'(start), 256'(1));
    check("flush_a", 256'(op_a), 256'(pat[162:0]));
    check("flush_b", 256'(op_b), 256'(pat[167:0]));
    step();
    check("flush_ops", 256'(ops_issued), 256'(3));

    // mul_done held high through a second load must not end WAIT.
    mul_done = 1'b1;
    step();
    load(32'h0F0F_0F0F, 18);
    in_valid = 1'b0;
    check("held_start", 256'(start), 256'(1));
    for (int i = 0; i < 5; i++) step();
    check("held_busy", 256'(busy), 256'(1));
    check("held_ready", 256'(in_ready), 256'(0));
    mul_done = 1'b0;
    step();
    check("held_low_busy", 256'(busy), 256'(1));
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    check("held_rise_ready", 256'(in_ready), 256'(1));
    check("held_ops", 256'(ops_issued), 256'(4));

    // Reset during word 12.
    load(32'h7777_7777, 11);
    #2 rst = 1'b0;
    #1 reset_check("rst_load");
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rst_load_ready", 256'(in_ready), 256'(1));
    load(32'h3333_3333, 17);
    check("rst_load_not_early", 256'(start), 256'(0));
    send(32'h3333_3333);
    in_valid = 1'b0;
    check("rst_load_start", 256'(start), 256'(1));
    step();
    check("rst_load_ops", 256'(ops_issued), 256'(1));

    // Reset during WAIT.
    step();
    #2 rst = 1'b0;
    #1 reset_check("rst_wait");
    step();
    rst = 1'b1;
    step();
    check("rst_wait_ready", 256'(in_ready), 256'(1));
    load(32'h0000_0001, 18);
    in_valid = 1'b0;
    check("rst_wait_start", 256'(start), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
